pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  REGADDR_WIDTH, 3, register-address width
  CNT_WIDTH, 16, performance-counter width
  WAIT_TIMEOUT, 255, maximum memory-wait cycles before halt
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  clk  in  1  single clock; all state changes on its rising edge
  reset  in  1  synchronous, active-low reset
  id_rs  in  REGADDR_WIDTH  source register 1 of the instruction in ID
  id_rt  in  REGADDR_WIDTH  source register 2 of the instruction in ID
  id_uses_rt  in  1  the ID instruction reads id_rt
  ex_mem_read  in  1  the EX instruction is a load
  ex_rd  in  REGADDR_WIDTH  destination register of the EX instruction
  ex_branch_taken  in  1  branch resolved taken in EX this cycle
  mem_req  in  1  the MEM stage is accessing data memory
  mem_ready  in  1  data memory completes the access this cycle
  pc_write  out  1  PC register load enable
  if_id_write  out  1  IF/ID register load enable
  if_id_flush  out  1  IF/ID loads a bubble
  id_ex_flush  out  1  ID/EX loads a bubble (drives the ID/EX flush input)
  pipe_hold  out  1  ID/EX, EX/MEM and MEM/WB keep their contents
  halt_err  out  1  sticky memory-timeout error
  stall_cnt  out  CNT_WIDTH  saturating count of cycles with pc_write=0
  flush_cnt  out  CNT_WIDTH  saturating count of branch flushes

Function
REQ-003 The FSM SHALL have three states: RUN, MEM_WAIT and HALT.
REQ-004 Control outputs SHALL be combinational from the current state and inputs (Mealy), taking effect in the same cycle.
REQ-005 Load-use hazard (lu) SHALL be: ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)); register 0 never hazards.
REQ-006 RUN priority SHALL be: memory stall > branch flush > load-use > normal.
REQ-007 In RUN with mem_req & !mem_ready: pc_write=0, if_id_write=0, pipe_hold=1, both flushes=0; next state MEM_WAIT; wait counter=1.
REQ-008 In RUN with ex_branch_taken and no memory stall: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, pipe_hold=0; flush_cnt increments; a coincident lu is ignored.
REQ-009 In RUN with lu only: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0, pipe_hold=0; stall lasts exactly one cycle.
REQ-010 In RUN with none of the above: pc_write=1, if_id_write=1, flushes=0, pipe_hold=0.
REQ-011 In MEM_WAIT with !mem_ready: outputs as in REQ-007; the wait counter increments; branch and lu are deferred, not lost.
REQ-012 In MEM_WAIT with mem_ready: the state returns to RUN and the outputs for that cycle follow the RUN rules REQ-008..REQ-010.
REQ-013 When the wait counter reaches WAIT_TIMEOUT in MEM_WAIT with !mem_ready, the next state SHALL be HALT and halt_err SHALL be set.
REQ-014 In HALT: pc_write=0, if_id_write=0, flushes=0, pipe_hold=1; HALT is exited only by reset.
REQ-015 stall_cnt and flush_cnt SHALL saturate at all-ones and never wrap.

Reset
REQ-016 While reset=0 at a rising edge: state<=RUN, wait counter<=0, stall_cnt<=0, flush_cnt<=0, halt_err<=0.
REQ-017 While reset=0, outputs SHALL be pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, pipe_hold=0, and the counters SHALL NOT count.
REQ-018 Reset asserted during MEM_WAIT or HALT SHALL return the block to RUN on the next edge with no residual hold.

Structure
REQ-019 The shared package pip_pkg SHALL hold the FSM state encoding, REGADDR_WIDTH and the WAIT_TIMEOUT default.
REQ-020 The load-use compare SHALL be one combinational sub-module, hazard_detect; the FSM and counters SHALL reside in pipe_hazard_ctrl.

Verification
REQ-021 ex_mem_read=1, ex_rd=3, id_rs=3 for one cycle -> exactly one cycle of pc_write=0 with id_ex_flush=1; stall_cnt=1.
REQ-022 ex_mem_read=1, ex_rd=0, id_rs=0 -> no stall; pc_write=1.
REQ-023 ex_branch_taken=1 together with lu (ex_rd=2, id_rt=2, id_uses_rt=1) -> both flushes=1, pc_write=1; flush_cnt=1.
REQ-024 mem_req=1, mem_ready=0 for 4 cycles with ex_branch_taken=1, then mem_ready=1 -> pipe_hold=1 for 4 cycles, then the flush in the release cycle; stall_cnt=4.
REQ-025 WAIT_TIMEOUT=8, mem_ready held 0 -> HALT after 8 wait cycles, halt_err=1; reset=0 for one cycle -> RUN, halt_err=0.
REQ-026 stall_cnt preloaded to near saturation via a long stall (CNT_WIDTH=4, 20 stall cycles) -> stall_cnt reads 15 and holds.

Source files
------------

// File: rtl/pip_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// default geometry.
package pip_pkg;

  localparam int unsigned DEF_REGADDR_WIDTH = 3;
  localparam int unsigned DEF_CNT_WIDTH     = 16;
  localparam int unsigned DEF_WAIT_TIMEOUT  = 255;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the EX load destination and ID sources.
module hazard_detect
  import pip_pkg::*;
#(
  parameter int unsigned REGADDR_WIDTH = DEF_REGADDR_WIDTH
) (
  input  logic [REGADDR_WIDTH-1:0] id_rs_i,
  input  logic [REGADDR_WIDTH-1:0] id_rt_i,
  input  logic                     id_uses_rt_i,
  input  logic                     ex_mem_read_i,
  input  logic [REGADDR_WIDTH-1:0] ex_rd_i,
  output logic                     load_use_c
);

  // Register 0 is hardwired, so a load targeting it can never hazard.
  assign load_use_c = ex_mem_read_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stall, branch flush, load-use
// stall, wait timeout halt and saturating performance counters.
module pipe_hazard_ctrl
  import pip_pkg::*;
#(
  parameter int unsigned REGADDR_WIDTH = DEF_REGADDR_WIDTH,
  parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int unsigned WAIT_TIMEOUT  = DEF_WAIT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REGADDR_WIDTH-1:0] id_rs,
  input  logic [REGADDR_WIDTH-1:0] id_rt,
  input  logic                     id_uses_rt,
  input  logic                     ex_mem_read,
  input  logic [REGADDR_WIDTH-1:0] ex_rd,
  input  logic                     ex_branch_taken,
  input  logic                     mem_req,
  input  logic                     mem_ready,
  output logic                     pc_write,
  output logic                     if_id_write,
  output logic                     if_id_flush,
  output logic                     id_ex_flush,
  output logic                     pipe_hold,
  output logic                     halt_err,
  output logic [CNT_WIDTH-1:0]     stall_cnt,
  output logic [CNT_WIDTH-1:0]     flush_cnt
);

  localparam int unsigned WCNT_WIDTH = $clog2(WAIT_TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic [WCNT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
  logic [WCNT_WIDTH-1:0]   wait_inc;
  logic [CNT_WIDTH-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]    flush_cnt_q, flush_cnt_d;
  logic                    halt_err_q, halt_err_d;
  logic                    load_use;
  logic                    mem_stall;
  logic                    branch_flush;

  hazard_detect #(
    .REGADDR_WIDTH (REGADDR_WIDTH)
  ) u_hazard_detect (
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rt_i  (id_uses_rt),
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd),
    .load_use_c    (load_use)
  );

  assign wait_inc  = wait_cnt_q + WCNT_WIDTH'(1);
  assign mem_stall = ((state_q == ST_RUN) && mem_req && !mem_ready) ||
                     ((state_q == ST_MEM_WAIT) && !mem_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      halt_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      halt_err_q  <= halt_err_d;
    end
  end

  // Next state and Mealy control outputs; branch and load-use are only
  // acted on once memory is no longer stalling, so nothing is lost.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    halt_err_d   = halt_err_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    pipe_hold    = 1'b0;
    branch_flush = 1'b0;
    if (!reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state_q)
        ST_HALT: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_hold   = 1'b1;
        end
        default: begin
          if (mem_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_hold   = 1'b1;
            state_d     = ST_MEM_WAIT;
            if (state_q == ST_RUN) begin
              wait_cnt_d = WCNT_WIDTH'(1);
            end else begin
              wait_cnt_d = wait_inc;
              if (wait_inc >= WCNT_WIDTH'(WAIT_TIMEOUT)) begin
                state_d    = ST_HALT;
                halt_err_d = 1'b1;
              end
            end
          end else begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
            if (ex_branch_taken) begin
              if_id_flush  = 1'b1;
              id_ex_flush  = 1'b1;
              branch_flush = 1'b1;
            end else if (load_use) begin
              pc_write    = 1'b0;
              if_id_write = 1'b0;
              id_ex_flush = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Saturating performance counters; frozen while reset is asserted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset && !pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
    if (branch_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign halt_err  = halt_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic against a behavioural model, on a default and a small instance.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;

  logic        pc0, ifw0, iff0, idf0, hold0, herr0;
  logic [15:0] sc0, fc0;
  logic        pc1, ifw1, iff1, idf1, hold1, herr1;
  logic [3:0]  sc1, fc1;

  typedef struct {
    int st;    // 0 running, 1 waiting on memory, 2 halted
    int wcnt;
    int scnt;
    int fcnt;
    int herr;
  } mdl_t;

  mdl_t m0, m1, n0, n1;
  logic [4:0] cap0, cap1;
  int n_chk  = 0;
  int n_pass = 0;
  int bias   = 2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc0), .if_id_write(ifw0),
    .if_id_flush(iff0), .id_ex_flush(idf0), .pipe_hold(hold0), .halt_err(herr0),
    .stall_cnt(sc0), .flush_cnt(fc0)
  );

  pipe_hazard_ctrl #(.CNT_WIDTH(4), .WAIT_TIMEOUT(8)) u_small (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc1), .if_id_write(ifw1),
    .if_id_flush(iff1), .id_ex_flush(idf1), .pipe_hold(hold1), .halt_err(herr1),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Expected controls {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}
  // and the state after the coming edge, from the written rules.
  function automatic void model_eval(input mdl_t m, input int tmo, input int cmax,
                                     output logic [4:0] ctl, output mdl_t n);
    bit lu, waiting;
    n  = m;
    lu = ex_mem_read && (ex_rd != 3'd0) &&
         ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    if (!reset) begin
      ctl = 5'b00110;
      n   = '{default: 0};
      return;
    end
    waiting = (m.st == 0 && mem_req && !mem_ready) || (m.st == 1 && !mem_ready);
    if (m.st == 2) begin
      ctl = 5'b00001;
    end else if (waiting) begin
      ctl    = 5'b00001;
      n.st   = 1;
      n.wcnt = (m.st == 0) ? 1 : m.wcnt + 1;
      if (m.st == 1 && n.wcnt >= tmo) begin
        n.st   = 2;
        n.herr = 1;
      end
    end else begin
      n.st = 0;
      if (ex_branch_taken) begin
        ctl = 5'b11110;
        if (n.fcnt < cmax) n.fcnt++;
      end else if (lu) begin
        ctl = 5'b00010;
      end else begin
        ctl = 5'b11000;
      end
    end
    if (!ctl[4] && n.scnt < cmax) n.scnt++;
  endfunction

  // One cycle: compare both instances against the model, then advance.
  task automatic step();
    logic [4:0] e0, e1;
    #1;
    model_eval(m0, 255, 65535, e0, n0);
    model_eval(m1, 8, 15, e1, n1);
    cap0 = {pc0, ifw0, iff0, idf0, hold0};
    cap1 = {pc1, ifw1, iff1, idf1, hold1};
    chk("d0_ctl",   32'(cap0),  32'(e0));
    chk("d0_halt",  32'(herr0), m0.herr);
    chk("d0_stall", 32'(sc0),   m0.scnt);
    chk("d0_flush", 32'(fc0),   m0.fcnt);
    chk("d1_ctl",   32'(cap1),  32'(e1));
    chk("d1_halt",  32'(herr1), m1.herr);
    chk("d1_stall", 32'(sc1),   m1.scnt);
    chk("d1_flush", 32'(fc1),   m1.fcnt);
    @(posedge clk);
    m0 = n0;
    m1 = n1;
    #1;
  endtask

  task automatic idle();
    reset = 1'b1; id_rs = 3'd0; id_rt = 3'd0; ex_rd = 3'd0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m0 = '{default: 0};
    m1 = '{default: 0};

    step();
    chk("reset_ctl", 32'(cap0), 32'(5'b00110));
    chk("reset_stall_cnt", 32'(sc0), 0);

    // Load-use on rs: one stall cycle then release
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3;
    step();
    chk("lu_stall_ctl", 32'(cap0), 32'(5'b00010));
    idle();
    step();
    chk("lu_release_ctl", 32'(cap0), 32'(5'b11000));
    chk("lu_stall_cnt", 32'(sc0), 1);

    // Register 0 never hazards
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 3'd0; id_rs = 3'd0;
    step();
    chk("r0_no_stall", 32'(cap0), 32'(5'b11000));

    // Branch wins over coincident load-use on rt
    do_reset();
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 3'd2; id_rt = 3'd2;
    id_uses_rt = 1'b1; id_rs = 3'd5;
    step();
    chk("br_lu_ctl", 32'(cap0), 32'(5'b11110));
    idle();
    step();
    chk("br_flush_cnt", 32'(fc0), 1);

    // Memory wait defers the branch to the release cycle
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("memwait_hold", 32'(cap0), 32'(5'b00001));
    end
    mem_ready = 1'b1;
    step();
    chk("memwait_release", 32'(cap0), 32'(5'b11110));
    idle();
    step();
    chk("memwait_stall_cnt", 32'(sc0), 4);
    chk("memwait_flush_cnt", 32'(fc0), 1);

    // Timeout to halt on the small instance, then reset recovers it
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (8) step();
    chk("timeout_halt_err", 32'(herr1), 1);
    mem_ready = 1'b1;
    step();
    chk("halt_ctl", 32'(cap1), 32'(5'b00001));
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("halt_cleared", 32'(herr1), 0);
    chk("halt_exit_ctl", 32'(cap1), 32'(5'b11000));

    // Long load-use stall saturates the narrow counter
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 3'd4; id_rs = 3'd4;
    repeat (20) step();
    idle();
    step();
    chk("sat_stall_cnt_small", 32'(sc1), 15);
    chk("sat_stall_cnt_wide", 32'(sc0), 20);

    // Random traffic, alternating easy and slow memory phases
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) bias = ($urandom_range(0, 1) == 0) ? 2 : 8;
      reset           = ($urandom_range(0, 39) != 0);
      id_rs           = 3'($urandom_range(0, 7));
      id_rt           = 3'($urandom_range(0, 7));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_rd           = ($urandom_range(0, 1) == 0) ? id_rs :
                        ($urandom_range(0, 1) == 0) ? id_rt : 3'($urandom_range(0, 7));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      mem_req         = ($urandom_range(0, 3) == 0);
      mem_ready       = ($urandom_range(0, bias - 1) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
